parity_sched: RTL and testbench

PARITY_SCHED -- requirements
Module: parity_sched

---
 rtl/parity_pkg.sv | 27 ++
 rtl/parity_acc.sv | 44 ++++
 rtl/parity_sched.sv | 146 ++++++++++++++
 tb/tb_parity_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the round-robin parity scheduler: FSM encoding,
// default sizing and a constant-friendly ceiling log2.
package parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/parity_acc.sv
// Serial XOR datapath: shifts a loaded word out LSB first into a one-bit
// accumulator, flagging the last bit of the word.
module parity_acc
    import parity_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             par_next_o,
    output logic             done_o
);

    localparam int CW = clog2(WIDTH) + 1;

    logic [WIDTH-1:0] sr_q;
    logic             acc_q;
    logic [CW-1:0]    cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            acc_q <= 1'b0;
            cnt_q <= '0;
        end else if (load_i) begin
            sr_q  <= din_i;
            acc_q <= 1'b0;
            cnt_q <= '0;
        end else if (en_i) begin
            sr_q  <= sr_q >> 1;
            acc_q <= acc_q ^ sr_q[0];
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Parity including the bit being consumed this cycle, so the final
    // result can be registered on the same edge that ends the shift.
    assign par_next_o = acc_q ^ sr_q[0];
    assign done_o     = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/parity_sched.sv
// Round-robin arbiter sharing one serial parity datapath among NREQ requesters.
//   state | meaning
//   IDLE  | no work, waiting for any req
//   LOAD  | winner granted; its word is captured at the closing edge
//   SHIFT | WIDTH cycles of serial XOR
//   DONE  | result strobe; re-arbitrate or fall back to IDLE
module parity_sched
    import parity_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int ODD   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    data,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     result_valid,
    output logic                     result,
    output logic [clog2(NREQ)-1:0]   result_id
);

    localparam int IDW = clog2(NREQ);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   winner_q, winner_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             rv_q, rv_d;
    logic             result_q, result_d;
    logic [IDW-1:0]   rid_q, rid_d;

    logic [IDW-1:0]        pick;
    logic [NREQ*WIDTH-1:0] data_sh;
    logic [WIDTH-1:0]      word;
    logic                  acc_load, acc_en, par_next, acc_done;

    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  p);
        logic [IDW-1:0]  sel;
        logic [NREQ-1:0] sh;
        logic            found;
        int              idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(p) + i) % NREQ;
            sh  = r >> idx;
            if (!found && sh[0]) begin
                sel   = IDW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick     = rr_pick(req, ptr_q);
    assign data_sh  = data >> (int'(winner_q) * WIDTH);
    assign word     = data_sh[WIDTH-1:0];
    assign acc_load = (state_q == ST_LOAD);
    assign acc_en   = (state_q == ST_SHIFT);

    parity_acc #(.WIDTH(WIDTH)) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (acc_load),
        .en_i       (acc_en),
        .din_i      (word),
        .par_next_o (par_next),
        .done_o     (acc_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            winner_q <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            rv_q     <= 1'b0;
            result_q <= 1'b0;
            rid_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            rv_q     <= rv_d;
            result_q <= result_d;
            rid_q    <= rid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        gnt_d    = '0;
        rv_d     = 1'b0;
        result_d = result_q;
        rid_d    = rid_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d  = ST_LOAD;
                    winner_d = pick;
                    gnt_d    = NREQ'(1) << pick;
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
                ptr_d   = (winner_q == IDW'(NREQ - 1)) ? '0 : winner_q + IDW'(1);
            end
            ST_SHIFT: begin
                if (acc_done) begin
                    state_d  = ST_DONE;
                    rv_d     = 1'b1;
                    result_d = par_next ^ 1'(ODD);
                    rid_d    = winner_q;
                end
            end
            ST_DONE: begin
                if (|req) begin
                    state_d  = ST_LOAD;
                    winner_d = pick;
                    gnt_d    = NREQ'(1) << pick;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign gnt          = gnt_q;
    assign busy         = busy_q;
    assign result_valid = rv_q;
    assign result       = result_q;
    assign result_id    = rid_q;

endmodule

// File: tb/tb_parity_sched.sv
// Self-checking bench: even and odd parity instances share stimulus and are
// compared against a transaction-level round-robin/parity reference.
module tb_parity_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int P     = WIDTH + 2;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req   = '0;
    logic [NREQ*WIDTH-1:0] data  = '0;

    logic [NREQ-1:0] gnt0, gnt1;
    logic            busy0, busy1, rv0, rv1, res0, res1;
    logic [1:0]      rid0, rid1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int m_ptr    = 0;

    logic [WIDTH-1:0] wd [NREQ];

    parity_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .ODD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data),
        .gnt(gnt0), .busy(busy0), .result_valid(rv0), .result(res0), .result_id(rid0)
    );

    parity_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .ODD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data),
        .gnt(gnt1), .busy(busy1), .result_valid(rv1), .result(res1), .result_id(rid1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_model(input logic [NREQ-1:0] m, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (m[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return 0;
    endfunction

    function automatic bit exp_par(input logic [WIDTH-1:0] w, input bit odd);
        return bit'($countones(w) % 2) ^ odd;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt0"}, 32'(gnt0), 0);
        chk({tag, "_gnt1"}, 32'(gnt1), 0);
        chk({tag, "_busy"}, {30'd0, busy0, busy1}, 0);
        chk({tag, "_rv"},   {30'd0, rv0, rv1}, 0);
        chk({tag, "_res"},  {30'd0, res0, res1}, 0);
        chk({tag, "_rid"},  {28'd0, rid0, rid1}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req   = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    // Apply mask and serve ngr grants. Drop mode releases each requester on its
    // grant; persist mode holds the mask until the last expected grant.
    task automatic run_batch(input logic [NREQ-1:0] mask, input bit persist, input int ngr);
        int              ord[$];
        logic [NREQ-1:0] pend;
        logic [NREQ-1:0] eg;
        int              p, w, e0, g, r, last;
        pend = mask;
        p    = m_ptr;
        for (int k = 0; k < ngr; k++) begin
            w = rr_model(pend, p);
            ord.push_back(w);
            p = (w + 1) % NREQ;
            if (!persist) pend[w] = 1'b0;
        end
        m_ptr = p;
        last  = ord[ngr-1];

        @(negedge clk);
        data = {wd[3], wd[2], wd[1], wd[0]};
        req  = mask;
        e0   = cyc + 1;
        g    = 0;
        r    = 0;
        for (int t = 0; t < ngr * P + 8 && r < ngr; t++) begin
            @(negedge clk);
            if (gnt0 !== '0 || gnt1 !== '0) begin
                eg = '0;
                if (g < ngr) eg[ord[g]] = 1'b1;
                chk("gnt", 32'(gnt0), 32'(eg));
                chk("gnt_odd", 32'(gnt1), 32'(eg));
                chk("gnt_time", cyc, e0 + g * P);
                chk("busy_at_gnt", {31'd0, busy0}, 1);
                if (g < ngr && !persist) req[ord[g]] = 1'b0;
                g++;
                if (persist && g == ngr) req = '0;
            end
            if (rv0 || rv1) begin
                w = (r < ngr) ? ord[r] : 0;
                chk("rv_pair", {31'd0, rv1}, {31'd0, rv0});
                chk("result", {31'd0, res0}, {31'd0, exp_par(wd[w], 1'b0)});
                chk("result_odd", {31'd0, res1}, {31'd0, exp_par(wd[w], 1'b1)});
                chk("result_id", 32'(rid0), w);
                chk("result_id_odd", 32'(rid1), w);
                chk("rv_time", cyc, e0 + WIDTH + 1 + r * P);
                chk("busy_at_rv", {31'd0, busy1}, 1);
                r++;
            end
        end
        chk("n_results", r, ngr);
        chk("n_grants", g, ngr);
        @(negedge clk);
        chk("idle_busy", {30'd0, busy0, busy1}, 0);
        chk("idle_rv", {30'd0, rv0, rv1}, 0);
        chk("idle_gnt", 32'(gnt0), 0);
        chk("hold_id", 32'(rid0), last);
        chk("hold_res", {31'd0, res0}, {31'd0, exp_par(wd[last], 1'b0)});
    endtask

    task automatic reset_mid_shift();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        wd[2] = 8'h5A;
        data  = {wd[3], wd[2], wd[1], wd[0]};
        req   = 4'b0100;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (gnt0 != '0) seen = 1'b1;
        end
        chk("mid_gnt_seen", {31'd0, seen}, 1);
        req = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("mid_rst_rv", {30'd0, rv0, rv1}, 0);
            chk("mid_rst_busy", {30'd0, busy0, busy1}, 0);
        end
        rst_n = 1'b1;
        m_ptr = 0;
        for (int t = 0; t < 2 * P; t++) begin
            @(negedge clk);
            chk("post_rst_quiet", {30'd0, rv0, rv1}, 0);
        end
        wd[1] = 8'h3C;
        wd[3] = 8'h80;
        run_batch(4'b1010, 1'b0, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] mask;
        bit              persist;
        int              ngr;
        for (int i = 0; i < NREQ; i++) wd[i] = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        m_ptr = 0;

        wd[0] = 8'hA5;
        run_batch(4'b0001, 1'b0, 1);
        wd[2] = 8'h07;
        run_batch(4'b0100, 1'b0, 1);

        do_reset();
        wd[0] = 8'h01; wd[1] = 8'h03; wd[2] = 8'h00; wd[3] = 8'hFF;
        run_batch(4'b1111, 1'b1, 4);

        do_reset();
        wd[0] = 8'h11; wd[3] = 8'h13;
        run_batch(4'b1001, 1'b1, 4);

        reset_mid_shift();

        for (int it = 0; it < 16; it++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            mask = NREQ'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) wd[i] = WIDTH'($urandom);
            persist = ($urandom_range(0, 3) == 0);
            ngr     = persist ? int'($urandom_range(1, 6)) : $countones(mask);
            run_batch(mask, persist, ngr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
